// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and types for the DDS tuning-word receiver
//
// Purpose: default tuning-word width, tuning-word type and the receiver state
// encoding shared by the receiver and its users.
// Ports: none (package).
package dds_pkg;

  localparam int FTW_W_DEF = 32;

  typedef logic [FTW_W_DEF-1:0] ftw_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ftw_rx_state_e;

endpackage

// File: rtl/dds_ftw_rx_sync_bit.sv
// rtl/dds_ftw_rx_sync_bit.sv - multi-stage synchroniser for one asynchronous input bit
//
// Purpose: brings one asynchronous level into the clk domain through a chain
// of STAGES flops. The chain presets to RESET_VAL so that an idle link looks
// idle straight out of reset and produces no spurious edges.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   d     - asynchronous input level
//   q     - synchronised level (last stage of the chain)
module sync_bit
  import dds_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dds_ftw_rx.sv
// rtl/dds_ftw_rx.sv - 3-wire serial receiver for the DDS frequency tuning word
//
// Purpose: oversamples sclk/cs_n/mosi in the clk domain, shifts in an MSB-first
// frame and, when a frame of exactly FTW_W bits closes, presents the word with
// a one-cycle update strobe for the phase-accumulator register bank.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   spi_sclk   - serial clock (asynchronous)
//   spi_cs_n   - frame select, active low (asynchronous)
//   spi_mosi   - serial data, MSB first (asynchronous)
//   ftw_o      - last accepted tuning word, held between updates
//   ftw_update - one-cycle pulse, ftw_o carries the new word in the same cycle
//   frame_err  - one-cycle pulse when a frame closes with a wrong bit count
//   busy       - high while a frame is open
module dds_ftw_rx
  import dds_pkg::*;
#(
  parameter int FTW_W       = FTW_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic [FTW_W-1:0] ftw_o,
  output logic             ftw_update,
  output logic             frame_err,
  output logic             busy
);

  // Counter must hold FTW_W+1 so that over-long frames stay distinguishable.
  localparam int CNT_W = $clog2(FTW_W + 2);

  logic sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, sclk_dd, cs_d, cs_dd, mosi_d;
  logic sclk_rise, cs_rise, cs_fall;

  ftw_rx_state_e    state, next_state;
  logic             start, shift_en, fall_pend;
  logic [CNT_W-1:0] bit_cnt;
  logic [FTW_W-1:0] shift_reg;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_sync)
  );
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_sync)
  );
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_sync)
  );

  // Edge detection runs one register behind the synchronisers; mosi is
  // delayed by the same amount so the sampled bit lines up with its sclk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d  <= 1'b0;
      sclk_dd <= 1'b0;
      cs_d    <= 1'b1;
      cs_dd   <= 1'b1;
      mosi_d  <= 1'b0;
    end else begin
      sclk_d  <= sclk_sync;
      sclk_dd <= sclk_d;
      cs_d    <= cs_sync;
      cs_dd   <= cs_d;
      mosi_d  <= mosi_sync;
    end
  end

  assign sclk_rise = sclk_d & ~sclk_dd;
  assign cs_rise   = cs_d & ~cs_dd;
  assign cs_fall   = ~cs_d & cs_dd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall || fall_pend) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        // Close of frame takes priority over a coincident sclk edge.
        if (cs_rise) begin
          next_state = DONE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // A new frame opening during DONE is remembered and started from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fall_pend <= 1'b0;
    end else if (state == DONE && cs_fall) begin
      fall_pend <= 1'b1;
    end else if (state == IDLE) begin
      fall_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (start) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[FTW_W-2:0], mosi_d};
      if (bit_cnt != CNT_W'(FTW_W + 1)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ftw_o      <= '0;
      ftw_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ftw_update <= 1'b0;
      frame_err  <= 1'b0;
      if (state == DONE) begin
        if (bit_cnt == CNT_W'(FTW_W)) begin
          ftw_o      <= shift_reg;
          ftw_update <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
